// File: rtl/cpu_pkg.sv
// Shared CPU widths and execution-unit requester indices used by the write-back path.
package cpu_pkg;
    localparam int REG_AW    = 5;
    localparam int DATA_W    = 32;
    localparam int STAMP_W   = 3;

    localparam int REQ_MOV   = 0;
    localparam int REQ_ALU   = 1;
    localparam int REQ_JUMP  = 2;
    localparam int REQ_FPU   = 3;
    localparam int REQ_IMM   = 4;
    localparam int NUM_UNITS = 5;
endpackage

// File: rtl/wb_rr_pick.sv
// Rotating-priority picker: first requester at or after ptr (with wrap) that is
// requesting and not excluded gets a one-hot grant.
module wb_rr_pick #(
    parameter int N  = 5,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  excl,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);
    always_comb begin
        int            cand;
        logic [IW-1:0] cidx;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        cidx  = '0;
        for (int off = 0; off < N; off++) begin
            cand = int'(ptr) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            cidx = IW'(cand);
            if (!found && req[cidx] && !excl[cidx]) begin
                found       = 1'b1;
                grant[cidx] = 1'b1;
                idx         = cidx;
            end
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: one holding buffer per execution unit, up to NUM_PORT
// round-robin grants per cycle onto registered reg_file write ports plus done pulses.
module wb_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_REQ  = cpu_pkg::NUM_UNITS,
    parameter int NUM_PORT = 2,
    parameter int REG_AW   = cpu_pkg::REG_AW,
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int STAMP_W  = cpu_pkg::STAMP_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*REG_AW-1:0]     req_addr_flat,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data_flat,
    input  logic [NUM_REQ*STAMP_W-1:0]    req_slot_flat,
    output logic [NUM_PORT-1:0]           wr_start,
    output logic [NUM_PORT*REG_AW-1:0]    wr_addr_flat,
    output logic [NUM_PORT*DATA_W-1:0]    wr_data_flat,
    output logic [NUM_PORT-1:0]           done_valid,
    output logic [NUM_PORT*STAMP_W-1:0]   done_slot_flat,
    output logic                          busy
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]  full_reg, full_next;
    logic [REG_AW-1:0]   addr_reg [NUM_REQ];
    logic [DATA_W-1:0]   data_reg [NUM_REQ];
    logic [STAMP_W-1:0]  slot_reg [NUM_REQ];
    logic [IW-1:0]       rr_ptr_reg, rr_ptr_next;
    logic                busy_reg;

    logic [NUM_PORT:0][NUM_REQ-1:0]   excl;
    logic [NUM_PORT-1:0][NUM_REQ-1:0] pick_grant;
    logic [NUM_PORT-1:0][IW-1:0]      pick_idx;
    logic [NUM_PORT-1:0]              pick_found;
    logic [NUM_REQ-1:0]               grant_any, accept;

    logic [NUM_PORT*REG_AW-1:0]  wr_addr_next, wr_addr_reg;
    logic [NUM_PORT*DATA_W-1:0]  wr_data_next, wr_data_reg;
    logic [NUM_PORT*STAMP_W-1:0] wr_slot_next, wr_slot_reg;
    logic [NUM_PORT-1:0]         wr_start_reg;

    // Each stage excludes requesters already granted and any buffer whose rd
    // matches a granted rd, so two writes to one register never share a cycle.
    assign excl[0] = '0;

    for (genvar gi = 0; gi < NUM_PORT; gi++) begin : g_port
        logic [REG_AW-1:0] g_addr;
        logic [NUM_REQ-1:0] g_hit;

        wb_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
            .req   (full_reg),
            .ptr   (rr_ptr_reg),
            .excl  (excl[gi]),
            .grant (pick_grant[gi]),
            .idx   (pick_idx[gi]),
            .found (pick_found[gi])
        );

        assign g_addr = addr_reg[pick_idx[gi]];

        for (genvar gj = 0; gj < NUM_REQ; gj++) begin : g_hit_bit
            assign g_hit[gj] = pick_found[gi] && (addr_reg[gj] == g_addr);
        end

        assign excl[gi+1] = excl[gi] | pick_grant[gi] | g_hit;

        assign wr_addr_next[gi*REG_AW +: REG_AW]   = pick_found[gi] ? g_addr : '0;
        assign wr_data_next[gi*DATA_W +: DATA_W]   = pick_found[gi] ? data_reg[pick_idx[gi]] : '0;
        assign wr_slot_next[gi*STAMP_W +: STAMP_W] = pick_found[gi] ? slot_reg[pick_idx[gi]] : '0;
    end

    always_comb begin
        grant_any   = '0;
        rr_ptr_next = rr_ptr_reg;
        for (int k = 0; k < NUM_PORT; k++) begin
            grant_any = grant_any | pick_grant[k];
            if (pick_found[k]) begin
                rr_ptr_next = (pick_idx[k] == IW'(NUM_REQ - 1)) ? '0 : pick_idx[k] + 1'b1;
            end
        end
    end

    assign req_ready = ~full_reg | grant_any;
    assign accept    = req_valid & req_ready;

    always_comb begin
        full_next = full_reg;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                full_next[i] = 1'b1;
            end else if (grant_any[i]) begin
                full_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                addr_reg[i] <= req_addr_flat[i*REG_AW +: REG_AW];
                data_reg[i] <= req_data_flat[i*DATA_W +: DATA_W];
                slot_reg[i] <= req_slot_flat[i*STAMP_W +: STAMP_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_reg     <= '0;
            rr_ptr_reg   <= '0;
            busy_reg     <= 1'b0;
            wr_start_reg <= '0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            wr_slot_reg  <= '0;
        end else begin
            full_reg     <= full_next;
            rr_ptr_reg   <= rr_ptr_next;
            busy_reg     <= |full_next;
            wr_start_reg <= pick_found;
            wr_addr_reg  <= wr_addr_next;
            wr_data_reg  <= wr_data_next;
            wr_slot_reg  <= wr_slot_next;
        end
    end

    assign wr_start       = wr_start_reg;
    assign wr_addr_flat   = wr_addr_reg;
    assign wr_data_flat   = wr_data_reg;
    assign done_valid     = wr_start_reg;
    assign done_slot_flat = wr_slot_reg;
    assign busy           = busy_reg;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: scoreboard of expected port writes plus per-scenario timing checks.
module tb_wb_arbiter;
    import cpu_pkg::*;

    localparam int NR = 5;
    localparam int NP = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NR-1:0]          req_valid, req_ready;
    logic [NR*REG_AW-1:0]   req_addr_flat;
    logic [NR*DATA_W-1:0]   req_data_flat;
    logic [NR*STAMP_W-1:0]  req_slot_flat;
    logic [NP-1:0]          wr_start, done_valid;
    logic [NP*REG_AW-1:0]   wr_addr_flat;
    logic [NP*DATA_W-1:0]   wr_data_flat;
    logic [NP*STAMP_W-1:0]  done_slot_flat;
    logic                   busy;

    logic [NR-1:0]          v1, r1;
    logic [NR*REG_AW-1:0]   a1;
    logic [NR*DATA_W-1:0]   d1;
    logic [NR*STAMP_W-1:0]  s1;
    logic [0:0]             ws1, dv1;
    logic [REG_AW-1:0]      wa1;
    logic [DATA_W-1:0]      wd1;
    logic [STAMP_W-1:0]     ds1;
    logic                   b1;

    wb_arbiter #(.NUM_REQ(NR), .NUM_PORT(NP)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr_flat(req_addr_flat), .req_data_flat(req_data_flat), .req_slot_flat(req_slot_flat),
        .wr_start(wr_start), .wr_addr_flat(wr_addr_flat), .wr_data_flat(wr_data_flat),
        .done_valid(done_valid), .done_slot_flat(done_slot_flat), .busy(busy)
    );

    wb_arbiter #(.NUM_REQ(NR), .NUM_PORT(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(v1), .req_ready(r1),
        .req_addr_flat(a1), .req_data_flat(d1), .req_slot_flat(s1),
        .wr_start(ws1), .wr_addr_flat(wa1), .wr_data_flat(wd1),
        .done_valid(dv1), .done_slot_flat(ds1), .busy(b1)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        int                  port;
        logic [REG_AW-1:0]   addr;
        logic [DATA_W-1:0]   data;
        logic [STAMP_W-1:0]  slot;
    } exp_t;
    exp_t sb_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int i, input logic [REG_AW-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [STAMP_W-1:0] s);
        req_valid[i] = 1'b1;
        req_addr_flat[i*REG_AW +: REG_AW]    = a;
        req_data_flat[i*DATA_W +: DATA_W]    = d;
        req_slot_flat[i*STAMP_W +: STAMP_W]  = s;
    endtask

    task automatic expect_wr(input int p, input logic [REG_AW-1:0] a, input logic [DATA_W-1:0] d,
                             input logic [STAMP_W-1:0] s);
        exp_t e;
        e.port = p; e.addr = a; e.data = d; e.slot = s;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        v1 = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '0; v1 = '0;
        step(); step();
        checks++;
        if ({wr_start, done_valid, wr_addr_flat, wr_data_flat, done_slot_flat, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got start=%b done=%b addr=%h data=%h slot=%h busy=%b required all 0",
                     wr_start, done_valid, wr_addr_flat, wr_data_flat, done_slot_flat, busy);
        end
        checks++;
        if ({ws1, dv1, wa1, wd1, ds1, b1} !== '0) begin
            failures++;
            $display("FAIL reset_outputs_p1 got start=%b addr=%h busy=%b required all 0", ws1, wa1, b1);
        end
        reset = 1'b0;
        step();
        checks++;
        if (req_ready !== 5'b11111 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got ready=%b busy=%b required 11111/0", req_ready, busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        post(REQ_ALU, 5'd3, 32'h0000_1234, 3'd2);
        expect_wr(0, 5'd3, 32'h0000_1234, 3'd2);
        step();
        req_valid = '0;
        checks++;
        if (wr_start !== 2'b00 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_edge_k got start=%b busy=%b required 00/1", wr_start, busy);
        end
        step();
        checks++;
        if (wr_start !== 2'b01 || wr_addr_flat[REG_AW-1:0] !== 5'd3 || done_slot_flat[STAMP_W-1:0] !== 3'd2) begin
            failures++;
            $display("FAIL single_write got start=%b addr=%0d slot=%0d required 01/3/2",
                     wr_start, wr_addr_flat[REG_AW-1:0], done_slot_flat[STAMP_W-1:0]);
        end
        checks++;
        if (wr_addr_flat[2*REG_AW-1:REG_AW] !== '0 || wr_data_flat[2*DATA_W-1:DATA_W] !== '0 ||
            done_slot_flat[2*STAMP_W-1:STAMP_W] !== '0) begin
            failures++;
            $display("FAIL single_port1_idle got addr=%h data=%h slot=%h required 0",
                     wr_addr_flat[2*REG_AW-1:REG_AW], wr_data_flat[2*DATA_W-1:DATA_W],
                     done_slot_flat[2*STAMP_W-1:STAMP_W]);
        end
        step();
        checks++;
        if (wr_start !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_after got start=%b busy=%b required 00/0", wr_start, busy);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_start [4];
        logic [4:0] exp_ready [4];
        exp_start = '{2'b11, 2'b11, 2'b01, 2'b00};
        exp_ready = '{5'b01111, 5'b11111, 5'b11111, 5'b11111};
        do_reset();
        for (int i = 0; i < NR; i++) begin
            post(i, REG_AW'(i + 1), DATA_W'(32'hA0 + i), STAMP_W'(i));
            expect_wr(i % 2, REG_AW'(i + 1), DATA_W'(32'hA0 + i), STAMP_W'(i));
        end
        step();
        req_valid = '0;
        checks++;
        if (req_ready !== 5'b00011) begin
            failures++;
            $display("FAIL contend_ready0 got %b required 00011", req_ready);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (wr_start !== exp_start[c] || req_ready !== exp_ready[c]) begin
                failures++;
                $display("FAIL contend_cycle%0d got start=%b ready=%b required %b/%b",
                         c, wr_start, req_ready, exp_start[c], exp_ready[c]);
            end
        end
    endtask

    task automatic test_collision();
        do_reset();
        post(REQ_MOV, 5'd7, 32'h70, 3'd1);
        post(REQ_JUMP, 5'd7, 32'h72, 3'd3);
        expect_wr(0, 5'd7, 32'h70, 3'd1);
        expect_wr(0, 5'd7, 32'h72, 3'd3);
        step();
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (wr_start !== ((c < 2) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("FAIL collide_cycle%0d got start=%b required %b", c, wr_start,
                         (c < 2) ? 2'b01 : 2'b00);
            end
        end
    endtask

    task automatic test_streaming();
        do_reset();
        for (int s = 0; s < 6; s++) begin
            if (s < 4) begin
                post(REQ_IMM, 5'd9, DATA_W'(32'h100 + s), STAMP_W'(s));
                expect_wr(0, 5'd9, DATA_W'(32'h100 + s), STAMP_W'(s));
                checks++;
                if (req_ready[REQ_IMM] !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_ready%0d got %b required 1", s, req_ready[REQ_IMM]);
                end
            end else begin
                req_valid = '0;
            end
            step();
            checks++;
            if (wr_start[0] !== ((s >= 1 && s <= 4) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL stream_start%0d got %b required %b", s, wr_start[0],
                         (s >= 1 && s <= 4));
            end
        end
    endtask

    task automatic test_fairness();
        logic [REG_AW-1:0] exp_a;
        do_reset();
        v1 = 5'b10001;
        a1 = '0; d1 = '0; s1 = '0;
        a1[0 +: REG_AW] = 5'd1;  d1[0 +: DATA_W] = 32'h10;  s1[0 +: STAMP_W] = 3'd0;
        a1[4*REG_AW +: REG_AW] = 5'd2; d1[4*DATA_W +: DATA_W] = 32'h40; s1[4*STAMP_W +: STAMP_W] = 3'd4;
        step();
        for (int s = 1; s <= 4; s++) begin
            step();
            exp_a = (s % 2 == 1) ? 5'd1 : 5'd2;
            checks++;
            if (ws1 !== 1'b1 || wa1 !== exp_a || ds1 !== ((s % 2 == 1) ? 3'd0 : 3'd4)) begin
                failures++;
                $display("FAIL fair_grant%0d got start=%b addr=%0d slot=%0d required 1/%0d",
                         s, ws1, wa1, ds1, exp_a);
            end
        end
        v1 = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        post(REQ_MOV, 5'd11, 32'hDEAD, 3'd5);
        post(REQ_ALU, 5'd12, 32'hBEEF, 3'd6);
        post(REQ_FPU, 5'd13, 32'hCAFE, 3'd7);
        step();
        req_valid = '0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_busy_before got %b required 1", busy);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({wr_start, done_valid, wr_addr_flat, wr_data_flat, done_slot_flat, busy} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs got start=%b addr=%h busy=%b required 0", wr_start, wr_addr_flat, busy);
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (done_valid !== 2'b00 || req_ready !== 5'b11111) begin
                failures++;
                $display("FAIL midrst_stale%0d got done=%b ready=%b required 00/11111", c, done_valid, req_ready);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0; req_addr_flat = '0; req_data_flat = '0; req_slot_flat = '0;
        v1 = '0; a1 = '0; d1 = '0; s1 = '0;

        fork
            begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    for (int k = 0; k < NP; k++) begin
                        checks++;
                        if (done_valid[k] !== wr_start[k]) begin
                            failures++;
                            $display("FAIL sb_done_coincident port%0d got done=%b required %b",
                                     k, done_valid[k], wr_start[k]);
                        end
                        if (wr_start[k] === 1'b1) begin
                            checks++;
                            if (sb_q.size() == 0) begin
                                failures++;
                                $display("FAIL sb_unexpected port%0d got addr=%0d data=%h slot=%0d required no write",
                                         k, wr_addr_flat[k*REG_AW +: REG_AW], wr_data_flat[k*DATA_W +: DATA_W],
                                         done_slot_flat[k*STAMP_W +: STAMP_W]);
                            end else begin
                                e = sb_q.pop_front();
                                if (e.port != k || wr_addr_flat[k*REG_AW +: REG_AW] !== e.addr ||
                                    wr_data_flat[k*DATA_W +: DATA_W] !== e.data ||
                                    done_slot_flat[k*STAMP_W +: STAMP_W] !== e.slot) begin
                                    failures++;
                                    $display("FAIL sb_write got port%0d addr=%0d data=%h slot=%0d required port%0d addr=%0d data=%h slot=%0d",
                                             k, wr_addr_flat[k*REG_AW +: REG_AW], wr_data_flat[k*DATA_W +: DATA_W],
                                             done_slot_flat[k*STAMP_W +: STAMP_W], e.port, e.addr, e.data, e.slot);
                                end
                            end
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_single();
        test_contention();
        test_collision();
        test_streaming();
        test_fairness();
        test_reset_mid();

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drained got %0d pending required 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
